// File: rtl/rename_regfile_pkg.sv
// Shared defaults and wiring types for the rename register file.
// Build option RENAME_REGFILE_BYPASS_EN enables same-cycle commit-to-read forwarding.
package rename_regfile_pkg;

    localparam int unsigned REGS_DEFAULT   = 8;
    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned TAG_W_DEFAULT  = 3;
    localparam int unsigned COMMIT_DEFAULT = 1;
    localparam int unsigned RA_W_DEFAULT   = $clog2(REGS_DEFAULT);

    typedef struct packed {
        logic                      valid;
        logic [RA_W_DEFAULT-1:0]   dest;
        logic [TAG_W_DEFAULT-1:0]  tag;
        logic [DATA_W_DEFAULT-1:0] data;
    } commit_t;

    function automatic logic tag_match(input logic [TAG_W_DEFAULT-1:0] stored,
                                       input logic [TAG_W_DEFAULT-1:0] retiring);
        return stored == retiring;
    endfunction

endpackage

// File: rtl/rename_regfile_entry.sv
// One architectural register: data word, busy bit and pending-producer tag.
// Priority: reset, then flush/dispatch for busy/tag; commit always writes data.
module rename_regfile_entry #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              disp_hit,
    input  logic [TAG_W-1:0]  disp_tag,
    input  logic              commit_hit,
    input  logic [TAG_W-1:0]  commit_tag,
    input  logic [DATA_W-1:0] commit_data,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [TAG_W-1:0]  tag
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            busy <= 1'b0;
            tag  <= '0;
        end else begin
            if (commit_hit) begin
                data <= commit_data;
            end
            // Flush drops a same-cycle dispatch; otherwise dispatch beats the commit's busy clear.
            if (flush) begin
                busy <= 1'b0;
            end else if (disp_hit) begin
                busy <= 1'b1;
                tag  <= disp_tag;
            end else if (commit_hit && (tag == commit_tag)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with rename status: decode, commit-port priority, read muxes.
// Define RENAME_REGFILE_BYPASS_EN to forward same-cycle commits onto the read ports.
module rename_regfile
    import rename_regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS   = REGS_DEFAULT,
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned TAG_W      = TAG_W_DEFAULT,
    parameter int unsigned NUM_RD     = 2,
    parameter int unsigned NUM_COMMIT = COMMIT_DEFAULT,
    localparam int unsigned RA_W      = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_RD*RA_W-1:0]       rd_addr,
    output logic [NUM_RD-1:0]            rd_busy,
    output logic [NUM_RD*TAG_W-1:0]      rd_tag,
    output logic [NUM_RD*DATA_W-1:0]     rd_data,
    input  logic                         disp_valid,
    input  logic [RA_W-1:0]              disp_dest,
    input  logic [TAG_W-1:0]             disp_tag,
    input  logic [NUM_COMMIT-1:0]        commit_valid,
    input  logic [NUM_COMMIT*RA_W-1:0]   commit_dest,
    input  logic [NUM_COMMIT*TAG_W-1:0]  commit_tag,
    input  logic [NUM_COMMIT*DATA_W-1:0] commit_data,
    input  logic                         flush
);

    logic              d_hit  [NUM_REGS];
    logic              c_hit  [NUM_REGS];
    logic [TAG_W-1:0]  c_tag  [NUM_REGS];
    logic [DATA_W-1:0] c_data [NUM_REGS];

    logic              r_busy [NUM_REGS];
    logic [TAG_W-1:0]  r_tag  [NUM_REGS];
    logic [DATA_W-1:0] r_data [NUM_REGS];

    // Ascending scan: the highest-index (youngest) matching port overrides older ones.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            d_hit[r]  = disp_valid && (disp_dest == RA_W'(r));
            c_hit[r]  = 1'b0;
            c_tag[r]  = '0;
            c_data[r] = '0;
            for (int unsigned i = 0; i < NUM_COMMIT; i++) begin
                if (commit_valid[i] && (commit_dest[i*RA_W +: RA_W] == RA_W'(r))) begin
                    c_hit[r]  = 1'b1;
                    c_tag[r]  = commit_tag[i*TAG_W +: TAG_W];
                    c_data[r] = commit_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        rename_regfile_entry #(
            .DATA_W (DATA_W),
            .TAG_W  (TAG_W)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .disp_hit    (d_hit[r]),
            .disp_tag    (disp_tag),
            .commit_hit  (c_hit[r]),
            .commit_tag  (c_tag[r]),
            .commit_data (c_data[r]),
            .data        (r_data[r]),
            .busy        (r_busy[r]),
            .tag         (r_tag[r])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [RA_W-1:0] addr;
        assign addr = rd_addr[p*RA_W +: RA_W];

`ifdef RENAME_REGFILE_BYPASS_EN
        always_comb begin
            rd_busy[p]                = r_busy[addr];
            rd_tag[p*TAG_W +: TAG_W]  = r_tag[addr];
            rd_data[p*DATA_W +: DATA_W] = r_data[addr];
            // Dispatch is never forwarded, so a same-cycle rename stays invisible here.
            if (c_hit[addr]) begin
                rd_data[p*DATA_W +: DATA_W] = c_data[addr];
                if (r_tag[addr] == c_tag[addr]) begin
                    rd_busy[p] = 1'b0;
                end
            end
        end
`else
        always_comb begin
            rd_busy[p]                  = r_busy[addr];
            rd_tag[p*TAG_W +: TAG_W]    = r_tag[addr];
            rd_data[p*DATA_W +: DATA_W] = r_data[addr];
        end
`endif
    end

endmodule
